// File: rtl/hazard_detection_unit_if.sv
// Hazard unit bundle: ID/EX operand info in, pipeline control out.
// master = pipeline side, slave = hazard_detection_unit.
interface hazard_detection_unit_if #(
  parameter int CNT_W = 16
);
  logic             IdEx_MemRead;
  logic [4:0]       IdEx_Rd;
  logic [4:0]       IfId_Rn;
  logic [4:0]       IfId_Rm;
  logic             IfId_UsesRm;
  logic             brTaken;
  logic             PCWrite;
  logic             IfIdWrite;
  logic             IdExBubble;
  logic             IfIdFlush;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output IdEx_MemRead, IdEx_Rd, IfId_Rn, IfId_Rm,
    output IfId_UsesRm, brTaken,
    input  PCWrite, IfIdWrite, IdExBubble, IfIdFlush,
    input  stallCount, flushCount
  );

  modport slave (
    input  IdEx_MemRead, IdEx_Rd, IfId_Rn, IfId_Rm,
    input  IfId_UsesRm, brTaken,
    output PCWrite, IfIdWrite, IdExBubble, IfIdFlush,
    output stallCount, flushCount
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// Load-use stall / taken-branch flush controller for the ID stage.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_detection_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  hazard_detection_unit_if.slave   hz
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);

  logic [0:0] state_q, state_d;
  logic [2:0] left_q, left_d;
  logic       load_use;
  logic       flush;
  logic       stall;

  // Hazard detect; XZR never hazards, branch beats load-use
  always_comb begin
    load_use = hz.IdEx_MemRead
             & (hz.IdEx_Rd != 5'd31)
             & ((hz.IdEx_Rd == hz.IfId_Rn)
             | (hz.IfId_UsesRm & (hz.IdEx_Rd == hz.IfId_Rm)));
    flush = hz.brTaken | (state_q == FLUSH);
    stall = ~flush & load_use;
  end

  // Control outputs, held at pass-through values during reset
  always_comb begin
    hz.PCWrite    = 1'b1;
    hz.IfIdWrite  = 1'b1;
    hz.IdExBubble = 1'b0;
    hz.IfIdFlush  = 1'b0;
    if (!reset) begin
      hz.PCWrite    = ~stall;
      hz.IfIdWrite  = ~stall;
      hz.IdExBubble = flush | stall;
      hz.IfIdFlush  = flush;
    end
  end

  // Next state: branch (re)loads the flush window, FLUSH counts down
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    if (hz.brTaken) begin
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        left_d  = RELOAD;
      end else begin
        state_d = RUN;
        left_d  = 3'd0;
      end
    end else if (state_q == FLUSH) begin
      if (left_q <= 3'd1) begin
        state_d = RUN;
        left_d  = 3'd0;
      end else begin
        left_d  = left_q - 3'd1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      left_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (hz.brTaken && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.stallCount = stall_cnt_q;
  assign hz.flushCount = flush_cnt_q;
`else
  assign hz.stallCount = '0;
  assign hz.flushCount = '0;
`endif

endmodule
